decode_stage_hz: RTL

- Parametrised decode stage for the custom pipelined processor: register file, instruction field decode, immediate sign-extension and the ID/EX pipeline register.
- Generalises widths and register count.
- Adds hold/flush control, source-address outputs for the forwarding unit, load-use hazard detection with automatic bubble insertion, and a saturating bubble counter.
- Sits between fetch (IF/ID) and execute.

---
 rtl/decode_stage_hz.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_hz.sv
// decode_stage_hz: decode stage between IF/ID and execute.
//   Contains the register file (write-through bypass), instruction field
//   decode, immediate sign-extension, the ID/EX pipeline register with
//   hold/flush, load-use hazard detection with automatic bubble insertion,
//   and a saturating count of inserted bubbles.
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   StallE / FlushE            hold ID/EX / load a bubble into ID/EX
//   RegWriteW, RdW, ResultW    writeback port into the register file
//   InstrD, PCD                instruction and its PC in decode
//   *E outputs                 registered ID/EX contents
//   RS1E, RS2E                 source addresses for the forwarding unit
//   LoadUseStallD              combinational; fetch must hold IF/ID
//   BubbleCount                bubbles inserted since reset (saturating)
module decode_stage_hz #(
  parameter int INSTR_W  = 20,
  parameter int DATA_W   = 19,
  parameter int PC_W     = 15,
  parameter int A_W      = 5,
  parameter int NUM_REGS = 19,
  parameter int OP_W     = 5,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic               RegWriteW,
  input  logic [A_W-1:0]     RdW,
  input  logic [DATA_W-1:0]  ResultW,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [PC_W-1:0]    PCD,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               JumpE,
  output logic               ALUSrcE,
  output logic               ResultSrcE,
  output logic               Cant_ByteE,
  output logic               ValidE,
  output logic [1:0]         BranchE,
  output logic [2:0]         ALUControlE,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [PC_W-1:0]    PCE,
  output logic [A_W-1:0]     RDE,
  output logic [A_W-1:0]     RS1E,
  output logic [A_W-1:0]     RS2E,
  output logic               LoadUseStallD,
  output logic [CNT_W-1:0]   BubbleCount
);

  localparam int IMM_W = INSTR_W - OP_W - 2*A_W;
  localparam logic [A_W:0] NREGS = NUM_REGS[A_W:0];

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              jump;
    logic              alu_src;
    logic              result_src;
    logic              cant_byte;
    logic              valid;
    logic [1:0]        branch;
    logic [2:0]        alu_ctl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   pc;
    logic [A_W-1:0]    rd;
    logic [A_W-1:0]    rs1;
    logic [A_W-1:0]    rs2;
  } idex_t;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  idex_t             r_idex;
  logic [CNT_W-1:0]  r_bcnt;

  logic [OP_W-1:0]   w_op;
  logic [A_W-1:0]    w_rd, w_rs1, w_rs2, w_srcb;
  logic [IMM_W-1:0]  w_imm;
  logic              w_is_store, w_is_branch;
  logic              w_load_use;
  idex_t             w_dec;

  assign w_op  = InstrD[OP_W-1:0];
  assign w_rd  = InstrD[OP_W +: A_W];
  assign w_rs1 = InstrD[OP_W+A_W +: A_W];
  assign w_rs2 = InstrD[OP_W+2*A_W +: A_W];
  assign w_imm = InstrD[INSTR_W-1 : OP_W+2*A_W];

  // Stores and branches carry their second source in the rd field.
  assign w_is_store  = (w_op[4:3] == 2'b10) && (w_op[2:1] == 2'b01);
  assign w_is_branch = (w_op[4:3] == 2'b11) && (w_op[2:0] != 3'd0) && (w_op[2] == 1'b0);
  assign w_srcb      = (w_is_store || w_is_branch) ? w_rd : w_rs2;

  function automatic logic in_range(input logic [A_W-1:0] a);
    return ({1'b0, a} < NREGS);
  endfunction

  // r0 and unimplemented addresses read zero; a same-cycle write wins.
  function automatic logic [DATA_W-1:0] rf_read(input logic [A_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    if (a != '0 && in_range(a)) begin
      if (RegWriteW && RdW == a) d = ResultW;
      else                       d = r_regs[a];
    end
    return d;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (RegWriteW && RdW != '0 && in_range(RdW)) begin
      r_regs[RdW] <= ResultW;
    end
  end

  always_comb begin
    w_dec       = '0;
    w_dec.valid = 1'b1;
    w_dec.rd1   = rf_read(w_rs1);
    w_dec.rd2   = rf_read(w_srcb);
    w_dec.imm   = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    w_dec.pc    = PCD;
    w_dec.rd    = w_rd;
    w_dec.rs1   = w_rs1;
    w_dec.rs2   = w_srcb;
    case (w_op[4:3])
      2'b00: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_ctl   = w_op[2:0];
      end
      2'b01: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_ctl   = w_op[2:0];
      end
      2'b10: begin
        case (w_op[2:0])
          3'b000: begin w_dec.alu_src = 1'b1; w_dec.reg_write = 1'b1; w_dec.result_src = 1'b1; end
          3'b001: begin w_dec.alu_src = 1'b1; w_dec.reg_write = 1'b1; w_dec.result_src = 1'b1;
                        w_dec.cant_byte = 1'b1; end
          3'b010: begin w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1; end
          3'b011: begin w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1; w_dec.cant_byte = 1'b1; end
          default: ;
        endcase
      end
      default: begin
        case (w_op[2:0])
          3'b000: begin w_dec.jump = 1'b1; w_dec.alu_src = 1'b1; end
          3'b001, 3'b010, 3'b011: begin
            w_dec.branch  = w_op[1:0];
            w_dec.alu_ctl = 3'b001;
          end
          default: ;
        endcase
      end
    endcase
  end

  // A load in execute whose destination feeds this instruction.
  assign w_load_use = r_idex.valid & r_idex.result_src & r_idex.reg_write &
                      (r_idex.rd != '0) & ((r_idex.rd == w_rs1) | (r_idex.rd == w_srcb));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idex <= '0;
      r_bcnt <= '0;
    end else if (FlushE || (!StallE && w_load_use)) begin
      r_idex <= '0;
      if (r_bcnt != '1) r_bcnt <= r_bcnt + 1'b1;
    end else if (!StallE) begin
      r_idex <= w_dec;
    end
  end

  assign RegWriteE     = r_idex.reg_write;
  assign MemWriteE     = r_idex.mem_write;
  assign JumpE         = r_idex.jump;
  assign ALUSrcE       = r_idex.alu_src;
  assign ResultSrcE    = r_idex.result_src;
  assign Cant_ByteE    = r_idex.cant_byte;
  assign ValidE        = r_idex.valid;
  assign BranchE       = r_idex.branch;
  assign ALUControlE   = r_idex.alu_ctl;
  assign RD1E          = r_idex.rd1;
  assign RD2E          = r_idex.rd2;
  assign ImmExtE       = r_idex.imm;
  assign PCE           = r_idex.pc;
  assign RDE           = r_idex.rd;
  assign RS1E          = r_idex.rs1;
  assign RS2E          = r_idex.rs2;
  assign LoadUseStallD = w_load_use;
  assign BubbleCount   = r_bcnt;

endmodule
